// File: rtl/datapath_pipe.sv
// Two-stage register-file datapath: stage 1 captures operands and control,
// stage 2 computes the ALU result, registers flags and writes back.
// Stage-1 ALU output is forwarded to an op issuing behind a writing op.
module datapath_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             in_valid,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic             wr,
  input  logic [2:0]       alu,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned SW = $clog2(WIDTH);

  logic [WIDTH-1:0] regs_q [NREGS];

  logic             s1_valid_q;
  logic             s1_wr_q;
  logic [2:0]       s1_alu_q;
  logic [AW-1:0]    s1_addr3_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;

  logic [WIDTH-1:0] result_q;
  logic             out_valid_q, cout_q, zero_q, ovf_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] diff_w;
  logic             lt_w;
  logic [WIDTH-1:0] op_a, op_b;
  logic             fwd_ok;

  // Stage-2 ALU: result, carry and signed overflow from the stage-1 operands.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff_w  = s1_a_q - s1_b_q;
    lt_w    = $signed(s1_a_q) < $signed(s1_b_q);
    case (s1_alu_q)
      3'b000: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      3'b001: begin
        alu_res = diff_w;
        alu_c   = (s1_a_q >= s1_b_q);  // no-borrow convention
        alu_v   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      3'b010: alu_res = s1_a_q & s1_b_q;
      3'b011: alu_res = s1_a_q | s1_b_q;
      3'b100: alu_res = s1_a_q ^ s1_b_q;
      3'b101: alu_res = {{(WIDTH-1){1'b0}}, lt_w};
      3'b110: alu_res = s1_a_q << s1_b_q[SW-1:0];
      default: alu_res = s1_a_q;
    endcase
  end

  // Operand read with forwarding from a writing op still in stage 1.
  always_comb begin
    fwd_ok = s1_valid_q && s1_wr_q;
    op_a   = regs_q[addr1];
    op_b   = regs_q[addr2];
    if (fwd_ok && (s1_addr3_q == addr1)) op_a = alu_res;
    if (fwd_ok && (s1_addr3_q == addr2)) op_b = alu_res;
  end

  // Stage-1 capture of operands and control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_wr_q    <= 1'b0;
      s1_alu_q   <= '0;
      s1_addr3_q <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_wr_q    <= wr;
        s1_alu_q   <= alu;
        s1_addr3_q <= addr3;
        s1_a_q     <= op_a;
        s1_b_q     <= op_b;
      end
    end
  end

  // Stage-2 result/flag registers; hold when no valid op completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= alu_res;
        cout_q   <= alu_c;
        zero_q   <= (alu_res == '0);
        ovf_q    <= alu_v;
      end
    end
  end

  // Register file: external load, then ALU writeback (later assignment wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (ld_en) regs_q[ld_addr] <= ld_data;
      if (s1_valid_q && s1_wr_q) regs_q[s1_addr3_q] <= alu_res;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed self-checking bench for datapath_pipe (WIDTH=32, NREGS=4).
module tb_datapath_pipe;

  logic        clk, rst;
  logic        ld_en;
  logic [1:0]  ld_addr;
  logic [31:0] ld_data;
  logic        in_valid;
  logic [1:0]  addr1, addr2, addr3;
  logic        wr;
  logic [2:0]  alu;
  logic [31:0] result;
  logic        out_valid, cout, zero, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  datapath_pipe #(.WIDTH(32), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_valid(in_valid), .addr1(addr1), .addr2(addr2), .addr3(addr3), .wr(wr),
    .alu(alu), .result(result), .out_valid(out_valid), .cout(cout), .zero(zero),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Drive one op for a single edge (E0); returns 1 ns after E0.
  task automatic issue(input logic [2:0] op, input logic [1:0] a1, input logic [1:0] a2,
                       input logic [1:0] a3, input logic w);
    alu = op; addr1 = a1; addr2 = a2; addr3 = a3; wr = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; wr = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    issue(3'b111, a, a, 2'd0, 1'b0);
    tick();
    v = result;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({out_valid, cout, zero, ovf} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {out_valid, cout, zero, ovf});
    end
    n_tests++;
    if (result !== 32'd0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", result);
    end
  endtask

  task automatic test_add();
    logic [31:0] v;
    load(2'd1, 32'd5);
    load(2'd2, 32'd3);
    issue(3'b000, 2'd1, 2'd2, 2'd3, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_early_valid: got %b want 0", out_valid);
    end
    tick();
    n_tests++;
    if ({out_valid, result, cout, zero, ovf} !== {1'b1, 32'd8, 3'b000}) begin
      n_fail++; $display("FAIL add_basic: got v=%b r=%h c/z/o=%b%b%b want v=1 r=8 000",
                         out_valid, result, cout, zero, ovf);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || result !== 32'd8) begin
      n_fail++; $display("FAIL add_pulse_hold: got v=%b r=%h want v=0 r=8", out_valid, result);
    end
    read_reg(2'd3, v);
    n_tests++;
    if (v !== 32'd8) begin
      n_fail++; $display("FAIL add_writeback: got %h want 8", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    load(2'd1, 32'd5);
    alu = 3'b000; addr1 = 2'd1; addr2 = 2'd1; addr3 = 2'd1; wr = 1'b1; in_valid = 1'b1;
    tick();
    addr3 = 2'd2;
    tick();
    in_valid = 1'b0; wr = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || result !== 32'd10) begin
      n_fail++; $display("FAIL b2b_first: got v=%b r=%h want v=1 r=a", out_valid, result);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || result !== 32'd20) begin
      n_fail++; $display("FAIL b2b_forward: got v=%b r=%h want v=1 r=14", out_valid, result);
    end
    read_reg(2'd1, v);
    n_tests++;
    if (v !== 32'd10) begin
      n_fail++; $display("FAIL b2b_r1: got %h want a", v);
    end
    read_reg(2'd2, v);
    n_tests++;
    if (v !== 32'd20) begin
      n_fail++; $display("FAIL b2b_r2: got %h want 14", v);
    end
  endtask

  task automatic test_add_flags();
    load(2'd1, 32'hFFFF_FFFF);
    load(2'd2, 32'd1);
    issue(3'b000, 2'd1, 2'd2, 2'd0, 1'b0);
    tick();
    n_tests++;
    if ({result, cout, zero, ovf} !== {32'd0, 3'b110}) begin
      n_fail++; $display("FAIL add_carry: got r=%h c/z/o=%b%b%b want r=0 110",
                         result, cout, zero, ovf);
    end
    load(2'd1, 32'h7FFF_FFFF);
    issue(3'b000, 2'd1, 2'd2, 2'd0, 1'b0);
    tick();
    n_tests++;
    if ({result, cout, zero, ovf} !== {32'h8000_0000, 3'b001}) begin
      n_fail++; $display("FAIL add_ovf: got r=%h c/z/o=%b%b%b want r=80000000 001",
                         result, cout, zero, ovf);
    end
  endtask

  task automatic test_sub_slt_shl();
    load(2'd1, 32'd3);
    load(2'd2, 32'd5);
    issue(3'b001, 2'd1, 2'd2, 2'd0, 1'b0);
    tick();
    n_tests++;
    if ({result, cout, zero, ovf} !== {32'hFFFF_FFFE, 3'b000}) begin
      n_fail++; $display("FAIL sub_borrow: got r=%h c/z/o=%b%b%b want r=fffffffe 000",
                         result, cout, zero, ovf);
    end
    issue(3'b001, 2'd2, 2'd1, 2'd0, 1'b0);
    tick();
    n_tests++;
    if ({result, cout, zero, ovf} !== {32'd2, 3'b100}) begin
      n_fail++; $display("FAIL sub_noborrow: got r=%h c/z/o=%b%b%b want r=2 100",
                         result, cout, zero, ovf);
    end
    load(2'd1, 32'hFFFF_FFFE);
    load(2'd2, 32'd1);
    issue(3'b101, 2'd1, 2'd2, 2'd0, 1'b0);
    tick();
    n_tests++;
    if ({result, cout, zero, ovf} !== {32'd1, 3'b000}) begin
      n_fail++; $display("FAIL slt_true: got r=%h c/z/o=%b%b%b want r=1 000",
                         result, cout, zero, ovf);
    end
    issue(3'b101, 2'd2, 2'd1, 2'd0, 1'b0);
    tick();
    n_tests++;
    if ({result, zero} !== {32'd0, 1'b1}) begin
      n_fail++; $display("FAIL slt_false: got r=%h z=%b want r=0 z=1", result, zero);
    end
    load(2'd1, 32'd1);
    load(2'd2, 32'd31);
    issue(3'b110, 2'd1, 2'd2, 2'd0, 1'b0);
    tick();
    n_tests++;
    if ({result, cout, zero, ovf} !== {32'h8000_0000, 3'b000}) begin
      n_fail++; $display("FAIL shl_31: got r=%h c/z/o=%b%b%b want r=80000000 000",
                         result, cout, zero, ovf);
    end
  endtask

  task automatic test_logic();
    logic [2:0]  ops [3];
    logic [31:0] exp [3];
    ops[0] = 3'b010; exp[0] = 32'h00F0_0034;
    ops[1] = 3'b011; exp[1] = 32'hFFF0_12FF;
    ops[2] = 3'b100; exp[2] = 32'hFF00_12CB;
    load(2'd1, 32'hF0F0_1234);
    load(2'd2, 32'h0FF0_00FF);
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 2'd1, 2'd2, 2'd0, 1'b0);
      tick();
      n_tests++;
      if ({result, cout, ovf} !== {exp[i], 2'b00}) begin
        n_fail++; $display("FAIL logic_op%0d: got r=%h c=%b o=%b want r=%h 00",
                           ops[i], result, cout, ovf, exp[i]);
      end
    end
  endtask

  task automatic test_load_visibility();
    logic [31:0] v;
    load(2'd1, 32'd5);
    // Load and op reading the same register on one edge: op sees the old value.
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 32'd11;
    issue(3'b111, 2'd1, 2'd1, 2'd0, 1'b0);
    ld_en = 1'b0;
    tick();
    n_tests++;
    if (result !== 32'd5) begin
      n_fail++; $display("FAIL load_not_fwd: got %h want 5", result);
    end
    read_reg(2'd1, v);
    n_tests++;
    if (v !== 32'd11) begin
      n_fail++; $display("FAIL load_visible: got %h want b", v);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    load(2'd1, 32'd3);
    load(2'd2, 32'd4);
    issue(3'b000, 2'd1, 2'd2, 2'd2, 1'b1);
    load(2'd2, 32'd9);  // lands on the writeback edge
    read_reg(2'd2, v);
    n_tests++;
    if (v !== 32'd7) begin
      n_fail++; $display("FAIL collide_same: got %h want 7", v);
    end
    load(2'd2, 32'd4);
    issue(3'b000, 2'd1, 2'd2, 2'd2, 1'b1);
    load(2'd0, 32'd9);
    read_reg(2'd2, v);
    n_tests++;
    if (v !== 32'd7) begin
      n_fail++; $display("FAIL collide_diff_wb: got %h want 7", v);
    end
    read_reg(2'd0, v);
    n_tests++;
    if (v !== 32'd9) begin
      n_fail++; $display("FAIL collide_diff_ld: got %h want 9", v);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] v;
    load(2'd1, 32'd6);
    load(2'd2, 32'd2);
    issue(3'b000, 2'd1, 2'd2, 2'd3, 1'b1);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || result !== 32'd0) begin
      n_fail++; $display("FAIL rst_async: got v=%b r=%h want v=0 r=0", out_valid, result);
    end
    #2 rst = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard_valid: got %b want 0", out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard_valid2: got %b want 0", out_valid);
    end
    read_reg(2'd3, v);
    n_tests++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL rst_no_wb: got %h want 0", v);
    end
    read_reg(2'd1, v);
    n_tests++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL rst_regs_clear: got %h want 0", v);
    end
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; in_valid = 1'b0;
    addr1 = '0; addr2 = '0; addr3 = '0; wr = 1'b0; alu = '0;
    #12;
    test_reset();
    rst = 1'b0;
    test_add();
    test_back_to_back();
    test_add_flags();
    test_sub_slt_shl();
    test_logic();
    test_load_visibility();
    test_collision();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, data and register width in bits (>= 8).
REQ-002 The module SHALL have parameter NREGS, default 4, number of registers, a power of two >= 2; AW = log2(NREGS).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ld_en  input  1  external register load strobe.
REQ-006 ld_addr  input  AW  load destination register.
REQ-007 ld_data  input  WIDTH  load value.
REQ-008 in_valid  input  1  issue an ALU operation this cycle.
REQ-009 addr1, addr2  input  AW each  source registers A, B.
REQ-010 addr3  input  AW  destination register.
REQ-011 wr  input  1  write result back to addr3 when 1.
REQ-012 alu  input  3  operation select.
REQ-013 result  output  WIDTH  registered ALU result.
REQ-014 out_valid  output  1  result/flags valid, one-cycle pulse per issued op.
REQ-015 cout, zero, ovf  output  1 each  registered carry, zero and signed-overflow flags.

Function
REQ-016 Stage 1 SHALL capture A, B, alu, addr3, wr and in_valid on the edge where in_valid=1 is sampled (edge E0); stage 2 SHALL compute and register result/flags on E0+1.
REQ-017 out_valid SHALL be 1 exactly in the cycle after E0+1; latency is 2 edges; one op per cycle is accepted with no stall.
REQ-018 Operations: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B, 101 signed A<B (result 1 or 0), 110 A << B[log2(WIDTH)-1:0], 111 pass A.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH; add: cout = carry-out of bit WIDTH-1; sub: cout = 1 when A >= B unsigned (no borrow); all other ops: cout=0.
REQ-020 ovf SHALL be the signed two's-complement overflow for add/sub and 0 for all other ops; zero SHALL be 1 iff result == 0.
REQ-021 Writeback of result to register addr3 SHALL occur on E0+1 when the captured wr=1; result, flags and out_valid SHALL update regardless of wr.
REQ-022 Forwarding: when stage 1 holds a valid op with wr=1 and its addr3 equals addr1 or addr2 of the op being issued, the issuing op SHALL read the stage-1 ALU output instead of the register file.
REQ-023 ld_en=1 SHALL write ld_data to ld_addr on the rising edge; loaded values are not forwarded and are visible to ops issued on the next edge or later.
REQ-024 ALU writeback and load to the same register on the same edge: writeback SHALL win; to different registers: both SHALL complete.
REQ-025 addr1 = addr2 SHALL be legal and SHALL return the same value for A and B.
REQ-026 With in_valid=0, stage 1 SHALL be marked invalid and no writeback or out_valid SHALL result from it; result and flags SHALL hold their last values.

Reset
REQ-027 While rst=1, all registers, result, cout, zero, ovf, out_valid and stage-1 valid SHALL be 0 immediately, independent of clk.
REQ-028 rst asserted with an op in flight SHALL discard it: no writeback and no out_valid after release.
REQ-029 The first op SHALL be accepted on the first rising edge with rst=0.

Verification (WIDTH=32, NREGS=4)
REQ-030 Load r1=5, r2=3; issue add r3=r1+r2 wr=1 -> out_valid pulse 2 edges later, result=8, cout=0, zero=0, ovf=0; later pass r3 -> 8.
REQ-031 r1=5; back-to-back issue r1=r1+r1 then r2=r1+r1 -> results 10 then 20 on consecutive cycles (forwarding).
REQ-032 add 0xFFFFFFFF+1 -> result 0, cout=1, zero=1, ovf=0; add 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
REQ-033 sub 3-5 -> 0xFFFFFFFE, cout=0, ovf=0; slt(-2,1) -> 1; shl(1,31) -> 0x80000000.
REQ-034 Writeback r2=7 and load r2=9 on the same edge -> r2 reads 7; load r0 same edge -> r0 reads 9.
REQ-035 rst pulse while an op with wr=1 is in stage 1 -> out_valid stays 0, target register reads 0 after release.
